// File: rtl/instr_fetch_prefetcher.sv
// Sequential instruction prefetcher: issues word fetches on a 1-cycle-latency memory port and
// buffers returned words with their addresses in a small FIFO for the core's valid/ready handshake.
module instr_fetch_prefetcher #(
  parameter int unsigned           ADDR_WIDTH = 18,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = 18'h20000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  output logic                  mem_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  instr_valid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_ready_i,
  output logic                  busy_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthCnt = DEPTH[CntW:0];

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] infl_addr_q;
  logic                  inflight_q;
  logic [CntW-1:0]       count_q, count_d;
  logic [PtrW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] target;
  logic [CntW:0]         occupancy;
  logic                  has_room;
  logic                  fifo_nonempty;
  logic                  push;
  logic                  pop;

  assign target        = {branch_addr_i[ADDR_WIDTH-1:2], 2'b00};
  // Outstanding request reserves a slot; a same-cycle pop is deliberately not credited.
  assign occupancy     = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
  assign has_room      = occupancy < DepthCnt;
  assign fifo_nonempty = count_q != '0;

  assign push          = inflight_q & ~branch_i;
  assign instr_valid_o = fifo_nonempty & ~branch_i;
  assign pop           = instr_valid_o & instr_ready_i;
  assign busy_o        = inflight_q | fifo_nonempty;
  assign instr_rdata_o = data_mem_q[rd_ptr_q];
  assign instr_addr_o  = addr_mem_q[rd_ptr_q];

  always_comb begin
    mem_en_o   = 1'b0;
    mem_addr_o = pc_q;
    if (branch_i) begin
      mem_en_o   = fetch_en_i;
      mem_addr_o = target;
    end else begin
      mem_en_o = fetch_en_i & has_room;
    end
    // Keep the memory port idle while reset is held.
    mem_en_o = mem_en_o & rst_n;
  end

  always_comb begin
    pc_d = pc_q;
    if (mem_en_o) begin
      pc_d = mem_addr_o + ADDR_WIDTH'(4);
    end else if (branch_i) begin
      pc_d = target;
    end
  end

  always_comb begin
    count_d = count_q;
    if (branch_i) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= BOOT_ADDR;
      inflight_q  <= 1'b0;
      infl_addr_q <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= mem_en_o;
      count_q    <= count_d;
      if (mem_en_o) begin
        infl_addr_q <= mem_addr_o;
      end
      if (branch_i) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= mem_rdata_i;
      addr_mem_q[wr_ptr_q] <= infl_addr_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_prefetcher.sv
// Directed bench for instr_fetch_prefetcher; memory model returns the request address as data.
module tb_instr_fetch_prefetcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [17:0] branch_addr_i = '0;
  logic        mem_en_o;
  logic [17:0] mem_addr_o;
  logic [31:0] mem_rdata_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_rdata_o;
  logic [17:0] instr_addr_o;
  logic        instr_ready_i = 1'b0;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_prefetcher dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en_i    (fetch_en_i),
    .branch_i      (branch_i),
    .branch_addr_i (branch_addr_i),
    .mem_en_o      (mem_en_o),
    .mem_addr_o    (mem_addr_o),
    .mem_rdata_i   (mem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_rdata_o (instr_rdata_o),
    .instr_addr_o  (instr_addr_o),
    .instr_ready_i (instr_ready_i),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  // 1-cycle latency memory: data equals the requested address.
  always @(posedge clk) begin
    if (mem_en_o) mem_rdata_i <= 32'(mem_addr_o);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are then driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic en, input logic rdy);
    rst_n = 1'b0;
    branch_i = 1'b0;
    fetch_en_i = en;
    instr_ready_i = rdy;
    #1;
    check("rst_mem_en", 32'(mem_en_o), 32'd0);
    check("rst_valid", 32'(instr_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // Sequential fetch, consumer always ready.
    do_reset(1'b1, 1'b1);
    check("t1_c0_en", 32'(mem_en_o), 32'd1);
    check("t1_c0_addr", 32'(mem_addr_o), 32'h20000);
    check("t1_c0_valid", 32'(instr_valid_o), 32'd0);
    tick();
    check("t1_c1_addr", 32'(mem_addr_o), 32'h20004);
    check("t1_c1_valid", 32'(instr_valid_o), 32'd0);
    check("t1_c1_busy", 32'(busy_o), 32'd1);
    tick();
    check("t1_c2_addr", 32'(mem_addr_o), 32'h20008);
    check("t1_c2_valid", 32'(instr_valid_o), 32'd1);
    check("t1_c2_iaddr", 32'(instr_addr_o), 32'h20000);
    check("t1_c2_idata", instr_rdata_o, 32'h00020000);
    tick();
    check("t1_c3_iaddr", 32'(instr_addr_o), 32'h20004);
    check("t1_c3_valid", 32'(instr_valid_o), 32'd1);

    // Backpressure: exactly DEPTH requests, then stall.
    do_reset(1'b1, 1'b0);
    check("t2_c0_addr", 32'(mem_addr_o), 32'h20000);
    tick();
    check("t2_c1_addr", 32'(mem_addr_o), 32'h20004);
    tick();
    check("t2_c2_addr", 32'(mem_addr_o), 32'h20008);
    tick();
    check("t2_c3_en", 32'(mem_en_o), 32'd1);
    check("t2_c3_addr", 32'(mem_addr_o), 32'h2000C);
    tick();
    check("t2_c4_en", 32'(mem_en_o), 32'd0);
    tick();
    check("t2_c5_en", 32'(mem_en_o), 32'd0);
    check("t2_c5_valid", 32'(instr_valid_o), 32'd1);
    instr_ready_i = 1'b1;
    #1;
    check("t2_c6_en", 32'(mem_en_o), 32'd0);
    check("t2_c6_iaddr", 32'(instr_addr_o), 32'h20000);
    tick();
    instr_ready_i = 1'b0;
    #1;
    check("t2_c7_en", 32'(mem_en_o), 32'd1);
    check("t2_c7_addr", 32'(mem_addr_o), 32'h20010);
    check("t2_c7_iaddr", 32'(instr_addr_o), 32'h20004);

    // Branch with 3 buffered and 0x2000C in flight.
    do_reset(1'b1, 1'b0);
    repeat (4) tick();
    check("t3_pre_valid", 32'(instr_valid_o), 32'd1);
    check("t3_pre_busy", 32'(busy_o), 32'd1);
    branch_i = 1'b1;
    branch_addr_i = 18'h00103;
    #1;
    check("t3_br_valid", 32'(instr_valid_o), 32'd0);
    check("t3_br_en", 32'(mem_en_o), 32'd1);
    check("t3_br_addr", 32'(mem_addr_o), 32'h00100);
    tick();
    branch_i = 1'b0;
    instr_ready_i = 1'b1;
    #1;
    check("t3_c1_valid", 32'(instr_valid_o), 32'd0);
    check("t3_c1_addr", 32'(mem_addr_o), 32'h00104);
    tick();
    check("t3_c2_valid", 32'(instr_valid_o), 32'd1);
    check("t3_c2_iaddr", 32'(instr_addr_o), 32'h00100);
    check("t3_c2_idata", instr_rdata_o, 32'h00000100);
    tick();
    check("t3_c3_iaddr", 32'(instr_addr_o), 32'h00104);

    // Address wrap at the top of the space.
    branch_i = 1'b1;
    branch_addr_i = 18'h3FFFC;
    #1;
    check("t4_br_addr", 32'(mem_addr_o), 32'h3FFFC);
    tick();
    branch_i = 1'b0;
    #1;
    check("t4_c1_addr", 32'(mem_addr_o), 32'h00000);
    tick();
    check("t4_c2_iaddr", 32'(instr_addr_o), 32'h3FFFC);
    check("t4_c2_idata", instr_rdata_o, 32'h0003FFFC);
    tick();
    check("t4_c3_iaddr", 32'(instr_addr_o), 32'h00000);
    check("t4_c3_valid", 32'(instr_valid_o), 32'd1);

    // fetch_en_i dropped after a single request.
    do_reset(1'b1, 1'b1);
    check("t5_c0_en", 32'(mem_en_o), 32'd1);
    tick();
    fetch_en_i = 1'b0;
    #1;
    check("t5_c1_en", 32'(mem_en_o), 32'd0);
    check("t5_c1_busy", 32'(busy_o), 32'd1);
    tick();
    check("t5_c2_valid", 32'(instr_valid_o), 32'd1);
    check("t5_c2_iaddr", 32'(instr_addr_o), 32'h20000);
    check("t5_c2_en", 32'(mem_en_o), 32'd0);
    tick();
    check("t5_c3_valid", 32'(instr_valid_o), 32'd0);
    check("t5_c3_busy", 32'(busy_o), 32'd0);
    check("t5_c3_en", 32'(mem_en_o), 32'd0);

    // Asynchronous reset with the FIFO full.
    do_reset(1'b1, 1'b0);
    repeat (6) tick();
    check("t6_full_valid", 32'(instr_valid_o), 32'd1);
    check("t6_full_en", 32'(mem_en_o), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(instr_valid_o), 32'd0);
    check("t6_rst_en", 32'(mem_en_o), 32'd0);
    check("t6_rst_busy", 32'(busy_o), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("t6_rel_en", 32'(mem_en_o), 32'd1);
    check("t6_rel_addr", 32'(mem_addr_o), 32'h20000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
